// File: rtl/word_queue_ctrl.sv
// word_queue_ctrl: typing-game sequencer. Maintains the five-word display
// window, the typed-character buffer and the cursor/score counters that the
// VGA text renderer and WPM/accuracy logic consume.
module word_queue_ctrl #(
  parameter int          NUM_WORDS    = 100,
  parameter int          TARGET_WORDS = 20,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         key_valid,
  input  logic [4:0]   key_code,
  output logic         key_ready,
  output logic [7:0]   cur_id,
  input  logic [4:0]   cur_len,
  input  logic [74:0]  cur_word,
  output logic [59:0]  rd,
  output logic [124:0] type_buf,
  output logic [4:0]   correct,
  output logic [4:0]   tot,
  output logic [9:0]   words_done,
  output logic [9:0]   chars_done,
  output logic [9:0]   err_cnt,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, FILL, RUN, REFILL, DONE} state_t;

  localparam logic [4:0] KEY_SPACE = 5'd27;
  localparam logic [4:0] KEY_BKSP  = 5'd28;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [7:0]  slot [5];
  logic [2:0]  fill_idx;

  logic        cand_ok;
  logic        is_letter;
  logic        letter_match;
  logic [4:0]  exp_ch;
  logic [10:0] chars_sum;
  logic [9:0]  chars_sat;
  logic [9:0]  err_inc;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1
  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign cand_ok   = {1'b0, lfsr[7:0]} < 9'(NUM_WORDS);
  assign is_letter = (key_code >= 5'd1) && (key_code <= 5'd26);

  // Dictionary character expected at the cursor; only consulted while tot < cur_len <= 15
  always_comb begin
    exp_ch = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      if (4'(i) == tot[3:0]) exp_ch = cur_word[5*i +: 5];
    end
  end

  assign letter_match = (correct == tot) && (tot < cur_len) && (key_code == exp_ch);

  // Saturating score arithmetic
  assign chars_sum = {1'b0, chars_done} + 11'(cur_len) + 11'd1;
  assign chars_sat = (chars_sum > 11'd1023) ? '1 : chars_sum[9:0];
  assign err_inc   = (err_cnt == '1) ? err_cnt : err_cnt + 10'd1;

  // Window packing: 8-bit ids in 10-bit fields, upper bits zero
  always_comb begin
    rd = '0;
    for (int unsigned k = 0; k < 5; k++) rd[10*k +: 8] = slot[k];
  end

  assign cur_id = slot[0];

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= SEED;
      fill_idx   <= '0;
      for (int unsigned k = 0; k < 5; k++) slot[k] <= '0;
      type_buf   <= '0;
      correct    <= '0;
      tot        <= '0;
      words_done <= '0;
      chars_done <= '0;
      err_cnt    <= '0;
      key_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      lfsr <= lfsr_next;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            for (int unsigned k = 0; k < 5; k++) slot[k] <= '0;
            type_buf   <= '0;
            correct    <= '0;
            tot        <= '0;
            words_done <= '0;
            chars_done <= '0;
            err_cnt    <= '0;
            fill_idx   <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            key_ready  <= 1'b0;
            state      <= FILL;
          end
        end
        FILL: begin
          if (cand_ok) begin
            for (int unsigned k = 0; k < 5; k++) begin
              if (3'(k) == fill_idx) slot[k] <= lfsr[7:0];
            end
            if (fill_idx == 3'd4) begin
              busy      <= 1'b0;
              key_ready <= 1'b1;
              state     <= RUN;
            end else begin
              fill_idx <= fill_idx + 3'd1;
            end
          end
        end
        REFILL: begin
          if (cand_ok) begin
            slot[4]   <= lfsr[7:0];
            busy      <= 1'b0;
            key_ready <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (key_valid && key_ready) begin
            if (is_letter) begin
              if (tot != 5'd25) begin
                for (int unsigned i = 0; i < 25; i++) begin
                  if (5'(i) == tot) type_buf[5*i +: 5] <= key_code;
                end
                tot <= tot + 5'd1;
                if (letter_match) correct <= correct + 5'd1;
                else              err_cnt <= err_inc;
              end
            end else if (key_code == KEY_BKSP) begin
              if (tot != 5'd0) begin
                for (int unsigned i = 0; i < 25; i++) begin
                  if (5'(i) + 5'd1 == tot) type_buf[5*i +: 5] <= '0;
                end
                tot <= tot - 5'd1;
                if (correct == tot) correct <= correct - 5'd1;
              end
            end else if (key_code == KEY_SPACE) begin
              if ((correct == cur_len) && (tot == cur_len)) begin
                for (int unsigned k = 0; k < 4; k++) slot[k] <= slot[k+1];
                slot[4]    <= '0;
                type_buf   <= '0;
                tot        <= '0;
                correct    <= '0;
                words_done <= words_done + 10'd1;
                chars_done <= chars_sat;
                key_ready  <= 1'b0;
                if (words_done == 10'(TARGET_WORDS - 1)) begin
                  done  <= 1'b1;
                  state <= DONE;
                end else begin
                  busy  <= 1'b1;
                  state <= REFILL;
                end
              end else begin
                err_cnt <= err_inc;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_queue_ctrl.sv
// Directed bench for word_queue_ctrl: one instance with NUM_WORDS=256 for the
// typing scenarios, one with NUM_WORDS=1/TARGET_WORDS=2 for rejection and
// round completion. A reference LFSR predicts the window contents.
module tb_word_queue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, kv0, start1, kv1;
  logic [4:0]  kc0, kc1;
  logic [4:0]  cur_len;
  logic [74:0] cur_word;

  logic         kr0, kr1, busy0, busy1, done0, done1;
  logic [7:0]   id0, id1;
  logic [59:0]  rd0, rd1;
  logic [124:0] tb0, tb1;
  logic [4:0]   cor0, cor1, tot0, tot1;
  logic [9:0]   wd0, wd1, cd0, cd1, ec0, ec1;

  word_queue_ctrl #(.NUM_WORDS(256), .TARGET_WORDS(20), .SEED(16'hACE1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .key_valid(kv0), .key_code(kc0),
    .key_ready(kr0), .cur_id(id0), .cur_len(cur_len), .cur_word(cur_word),
    .rd(rd0), .type_buf(tb0), .correct(cor0), .tot(tot0), .words_done(wd0),
    .chars_done(cd0), .err_cnt(ec0), .busy(busy0), .done(done0));

  word_queue_ctrl #(.NUM_WORDS(1), .TARGET_WORDS(2), .SEED(16'hACE1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .key_valid(kv1), .key_code(kc1),
    .key_ready(kr1), .cur_id(id1), .cur_len(cur_len), .cur_word(cur_word),
    .rd(rd1), .type_buf(tb1), .correct(cor1), .tot(tot1), .words_done(wd1),
    .chars_done(cd1), .err_cnt(ec1), .busy(busy1), .done(done1));

  // Reference LFSR: taps 16,14,13,11 as a parity mask on the outgoing bits
  logic [15:0] m;
  always @(posedge clk) begin
    if (rst) m <= 16'hACE1;
    else     m <= {^(m & 16'h002D), m[15:1]};
  end

  int vecs = 0;
  int errs = 0;
  logic [7:0] es [5];

  function automatic logic [59:0] pack_exp();
    logic [59:0] r;
    r = '0;
    for (int k = 0; k < 5; k++) r[10*k +: 8] = es[k];
    return r;
  endfunction

  task automatic press(input bit inst, input logic [4:0] code);
    if (inst) begin kv1 = 1'b1; kc1 = code; end
    else      begin kv0 = 1'b1; kc0 = code; end
    @(negedge clk);
    kv0 = 1'b0;
    kv1 = 1'b0;
  endtask

  task automatic pulse_start(input bit inst);
    if (inst) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Predicts slot writes from the reference LFSR; counts DUT busy cycles meanwhile
  task automatic run_fill(input bit inst, input int nw, input int first,
                          output int got, output int ncyc, output int nbusy);
    got = first; ncyc = 0; nbusy = 0;
    while (got < 5 && ncyc < 15000) begin
      if (int'(m[7:0]) < nw) begin
        es[got] = m[7:0];
        got++;
        if (first == 4) got = 5;
      end
      if ((inst ? busy1 : busy0) === 1'b1) nbusy++;
      @(negedge clk);
      ncyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if ({kr0, id0, rd0, tb0, cor0, tot0, wd0, cd0, ec0, busy0, done0} !== '0) begin
      errs++; $display("FAIL reset_u0: got outputs nonzero rd=%0h type=%0h", rd0, tb0);
    end
    vecs++;
    if ({kr1, id1, rd1, tb1, cor1, tot1, wd1, cd1, ec1, busy1, done1} !== '0) begin
      errs++; $display("FAIL reset_u1: got outputs nonzero busy=%0b kr=%0b", busy1, kr1);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    int got, n, nb;
    pulse_start(1'b0);
    vecs++;
    if (busy0 !== 1'b1 || kr0 !== 1'b0) begin
      errs++; $display("FAIL fill_enter: busy=%0b kr=%0b required 1/0", busy0, kr0);
    end
    run_fill(1'b0, 256, 0, got, n, nb);
    vecs++;
    if (nb !== 5 || got !== 5) begin
      errs++; $display("FAIL fill_len: busy cycles %0d required 5", nb);
    end
    vecs++;
    if (busy0 !== 1'b0 || kr0 !== 1'b1) begin
      errs++; $display("FAIL fill_exit: busy=%0b kr=%0b required 0/1", busy0, kr0);
    end
    vecs++;
    if (rd0 !== pack_exp() || id0 !== es[0]) begin
      errs++; $display("FAIL fill_window: rd=%0h required %0h", rd0, pack_exp());
    end
  endtask

  task automatic test_word_accept();
    int got, n, nb;
    press(1'b0, 5'd3); press(1'b0, 5'd1); press(1'b0, 5'd20);
    vecs++;
    if (tb0[14:0] !== {5'd20, 5'd1, 5'd3} || tot0 !== 5'd3 || cor0 !== 5'd3 || ec0 !== 10'd0) begin
      errs++; $display("FAIL cat_typed: type=%0h tot=%0d cor=%0d err=%0d required 5023/3/3/0", tb0[14:0], tot0, cor0, ec0);
    end
    press(1'b0, 5'd27);
    for (int k = 0; k < 4; k++) es[k] = es[k+1];
    es[4] = 8'd0;
    vecs++;
    if (tb0 !== '0 || tot0 !== 5'd0 || cor0 !== 5'd0 || wd0 !== 10'd1 || cd0 !== 10'd4) begin
      errs++; $display("FAIL accept_counts: tot=%0d cor=%0d wd=%0d cd=%0d required 0/0/1/4", tot0, cor0, wd0, cd0);
    end
    vecs++;
    if (busy0 !== 1'b1 || kr0 !== 1'b0 || rd0 !== pack_exp()) begin
      errs++; $display("FAIL accept_shift: busy=%0b rd=%0h required 1/%0h", busy0, rd0, pack_exp());
    end
    run_fill(1'b0, 256, 4, got, n, nb);
    vecs++;
    if (kr0 !== 1'b1 || nb !== 1 || rd0 !== pack_exp()) begin
      errs++; $display("FAIL refill: kr=%0b busy cycles=%0d rd=%0h required 1/1/%0h", kr0, nb, rd0, pack_exp());
    end
  endtask

  task automatic test_backspace();
    int got, n, nb;
    press(1'b0, 5'd3); press(1'b0, 5'd2); press(1'b0, 5'd20);
    vecs++;
    if (cor0 !== 5'd1 || tot0 !== 5'd3 || ec0 !== 10'd2) begin
      errs++; $display("FAIL typo: cor=%0d tot=%0d err=%0d required 1/3/2", cor0, tot0, ec0);
    end
    press(1'b0, 5'd28); press(1'b0, 5'd28);
    vecs++;
    if (tot0 !== 5'd1 || cor0 !== 5'd1 || tb0[14:5] !== 10'd0 || tb0[4:0] !== 5'd3) begin
      errs++; $display("FAIL backspace: tot=%0d cor=%0d type=%0h required 1/1/3", tot0, cor0, tb0[14:0]);
    end
    press(1'b0, 5'd1); press(1'b0, 5'd20);
    vecs++;
    if (cor0 !== 5'd3 || ec0 !== 10'd2 || tot0 !== 5'd3) begin
      errs++; $display("FAIL retype: cor=%0d err=%0d tot=%0d required 3/2/3", cor0, ec0, tot0);
    end
    press(1'b0, 5'd27);
    for (int k = 0; k < 4; k++) es[k] = es[k+1];
    es[4] = 8'd0;
    run_fill(1'b0, 256, 4, got, n, nb);
    vecs++;
    if (wd0 !== 10'd2 || cd0 !== 10'd8 || rd0 !== pack_exp()) begin
      errs++; $display("FAIL second_word: wd=%0d cd=%0d rd=%0h required 2/8/%0h", wd0, cd0, rd0, pack_exp());
    end
  endtask

  task automatic test_errors_limits();
    int got, n, nb;
    press(1'b0, 5'd3); press(1'b0, 5'd1);
    press(1'b0, 5'd27);
    vecs++;
    if (ec0 !== 10'd3 || tot0 !== 5'd2 || cor0 !== 5'd2 || wd0 !== 10'd2 || rd0 !== pack_exp() || kr0 !== 1'b1) begin
      errs++; $display("FAIL early_space: err=%0d tot=%0d wd=%0d rd=%0h required 3/2/2/%0h", ec0, tot0, wd0, rd0, pack_exp());
    end
    press(1'b0, 5'd28); press(1'b0, 5'd28); press(1'b0, 5'd28);
    vecs++;
    if (tot0 !== 5'd0 || cor0 !== 5'd0 || ec0 !== 10'd3 || tb0 !== '0) begin
      errs++; $display("FAIL bksp_empty: tot=%0d cor=%0d err=%0d required 0/0/3", tot0, cor0, ec0);
    end
    for (int i = 0; i < 25; i++) press(1'b0, 5'd1);
    vecs++;
    if (tot0 !== 5'd25 || ec0 !== 10'd28) begin
      errs++; $display("FAIL fill_25: tot=%0d err=%0d required 25/28", tot0, ec0);
    end
    press(1'b0, 5'd1);
    vecs++;
    if (tot0 !== 5'd25 || ec0 !== 10'd28 || tb0 !== {25{5'd1}}) begin
      errs++; $display("FAIL overflow_26: tot=%0d err=%0d type=%0h required 25/28/all-ones-chars", tot0, ec0, tb0);
    end
    for (int i = 0; i < 25; i++) press(1'b0, 5'd28);
    press(1'b0, 5'd3); press(1'b0, 5'd1); press(1'b0, 5'd20); press(1'b0, 5'd27);
    for (int k = 0; k < 4; k++) es[k] = es[k+1];
    es[4] = 8'd0;
    kv0 = 1'b1; kc0 = 5'd3;
    run_fill(1'b0, 256, 4, got, n, nb);
    kv0 = 1'b0;
    vecs++;
    if (tot0 !== 5'd0 || cor0 !== 5'd0 || ec0 !== 10'd28 || wd0 !== 10'd3 || cd0 !== 10'd12 || tb0 !== '0) begin
      errs++; $display("FAIL key_in_refill: tot=%0d cor=%0d err=%0d wd=%0d cd=%0d required 0/0/28/3/12", tot0, cor0, ec0, wd0, cd0);
    end
  endtask

  task automatic test_reset_midway();
    int got, n, nb;
    start0 = 1'b1; kv0 = 1'b1; kc0 = 5'd3; rst = 1'b1;
    @(negedge clk);
    vecs++;
    if ({kr0, id0, rd0, tb0, cor0, tot0, wd0, cd0, ec0, busy0, done0} !== '0) begin
      errs++; $display("FAIL rst_in_run: rd=%0h wd=%0d err=%0d required all 0", rd0, wd0, ec0);
    end
    rst = 1'b0; start0 = 1'b0; kv0 = 1'b0;
    pulse_start(1'b0);
    run_fill(1'b0, 256, 0, got, n, nb);
    press(1'b0, 5'd3); press(1'b0, 5'd1); press(1'b0, 5'd20); press(1'b0, 5'd27);
    vecs++;
    if (busy0 !== 1'b1 || wd0 !== 10'd1) begin
      errs++; $display("FAIL pre_rst_refill: busy=%0b wd=%0d required 1/1", busy0, wd0);
    end
    rst = 1'b1; start0 = 1'b1; kv0 = 1'b1;
    @(negedge clk);
    vecs++;
    if ({kr0, id0, rd0, tb0, cor0, tot0, wd0, cd0, ec0, busy0, done0} !== '0) begin
      errs++; $display("FAIL rst_in_refill: busy=%0b wd=%0d rd=%0h required all 0", busy0, wd0, rd0);
    end
    rst = 1'b0; start0 = 1'b0; kv0 = 1'b0;
    @(negedge clk);
    vecs++;
    if (busy0 !== 1'b0 || kr0 !== 1'b0) begin
      errs++; $display("FAIL idle_hold: busy=%0b kr=%0b required 0/0", busy0, kr0);
    end
    pulse_start(1'b0);
    run_fill(1'b0, 256, 0, got, n, nb);
    vecs++;
    if (nb !== 5 || rd0 !== pack_exp()) begin
      errs++; $display("FAIL seed_restart: busy cycles=%0d rd=%0h required 5/%0h", nb, rd0, pack_exp());
    end
  endtask

  task automatic test_target_done();
    int got, n, nb;
    pulse_start(1'b1);
    run_fill(1'b1, 1, 0, got, n, nb);
    vecs++;
    if (got !== 5 || nb !== n || busy1 !== 1'b0 || kr1 !== 1'b1) begin
      errs++; $display("FAIL reject_fill: busy cycles=%0d required %0d (slots %0d), kr=%0b", nb, n, got, kr1);
    end
    press(1'b1, 5'd3); press(1'b1, 5'd1); press(1'b1, 5'd20); press(1'b1, 5'd27);
    vecs++;
    if (wd1 !== 10'd1 || cd1 !== 10'd4 || busy1 !== 1'b1 || done1 !== 1'b0) begin
      errs++; $display("FAIL t1_first_word: wd=%0d cd=%0d busy=%0b done=%0b required 1/4/1/0", wd1, cd1, busy1, done1);
    end
    run_fill(1'b1, 1, 4, got, n, nb);
    vecs++;
    if (got !== 5 || nb !== n || kr1 !== 1'b1) begin
      errs++; $display("FAIL reject_refill: busy cycles=%0d required %0d, kr=%0b", nb, n, kr1);
    end
    press(1'b1, 5'd3); press(1'b1, 5'd1); press(1'b1, 5'd20); press(1'b1, 5'd27);
    vecs++;
    if (done1 !== 1'b1 || kr1 !== 1'b0 || busy1 !== 1'b0 || wd1 !== 10'd2 || cd1 !== 10'd8) begin
      errs++; $display("FAIL round_done: done=%0b kr=%0b busy=%0b wd=%0d cd=%0d required 1/0/0/2/8", done1, kr1, busy1, wd1, cd1);
    end
    press(1'b1, 5'd3);
    vecs++;
    if (tot1 !== 5'd0 || ec1 !== 10'd0 || done1 !== 1'b1) begin
      errs++; $display("FAIL done_hold: tot=%0d err=%0d done=%0b required 0/0/1", tot1, ec1, done1);
    end
    pulse_start(1'b1);
    vecs++;
    if (wd1 !== 10'd0 || cd1 !== 10'd0 || ec1 !== 10'd0 || done1 !== 1'b0 || busy1 !== 1'b1) begin
      errs++; $display("FAIL restart: wd=%0d cd=%0d done=%0b busy=%0b required 0/0/0/1", wd1, cd1, done1, busy1);
    end
    run_fill(1'b1, 1, 0, got, n, nb);
    vecs++;
    if (got !== 5 || nb !== n || kr1 !== 1'b1) begin
      errs++; $display("FAIL restart_fill: busy cycles=%0d required %0d, kr=%0b", nb, n, kr1);
    end
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; kv0 = 1'b0; kv1 = 1'b0;
    kc0 = '0; kc1 = '0;
    cur_len  = 5'd3;
    cur_word = {60'd0, 5'd20, 5'd1, 5'd3};
    for (int k = 0; k < 5; k++) es[k] = 8'd0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_word_accept();
    test_backspace();
    test_errors_limits();
    test_reset_midway();
    test_target_done();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/word_queue_ctrl.md
Name: word_queue_ctrl

Overview:
- Game sequencer that feeds the VGA text display path.
- Owns the five-word display window (packed id array `rd`), the typed-character buffer (`type`), and the `correct`/`tot` cursor counters consumed by the renderer.
- Consumes decoded key events and pulls random dictionary ids from an internal LFSR.
- Scores progress (words, characters, errors) for the WPM/accuracy logic.

Parameters:
- NUM_WORDS, 100, valid dictionary ids are 0..NUM_WORDS-1 (1..256).
- TARGET_WORDS, 20, accepted words that end a round (1..1023).
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a round; honoured only in IDLE or DONE.
- key_valid  in  1  key event strobe.
- key_code  in  5  1..26 = a..z, 27 = space, 28 = backspace; others are ignored but still accepted.
- key_ready  out  1  high only in RUN; a key is accepted when key_valid && key_ready at a clk edge.
- cur_id  out  8  id of window slot 0, driven to the external combinational dictionary.
- cur_len  in  5  dictionary length for cur_id (1..15).
- cur_word  in  75  dictionary text; char i is at [5i +: 5].
- rd  out  60  window; slot k at [10k +: 10] with bits 7:0 = id and bits 9:8 = 0; bits 59:50 = 0.
- type  out  125  typed buffer; char i at [5i +: 5]; unused positions are 0.
- correct  out  5  length of the matching prefix.
- tot  out  5  number of chars typed (0..25).
- words_done  out  10  accepted words this round.
- chars_done  out  10  sum over accepted words of (cur_len+1); saturates at 1023.
- err_cnt  out  10  error events; saturates at 1023.
- busy  out  1  high in FILL or REFILL.
- done  out  1  high in DONE.

Behaviour:
- All outputs are registered; an effect is visible the cycle after the accepting edge.
- Reset: state IDLE; every output 0 except cur_id = 0; LFSR = SEED.
- Reset mid-operation (any state, including FILL/REFILL) takes priority over all other inputs and returns to this state.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1; shifts every cycle in every state except during reset. Candidate id = lfsr[7:0] of the current cycle.
- IDLE: start -> FILL. Clear type, tot, correct, words_done, chars_done, err_cnt, and rd.
- FILL: slot index s starts at 0.
  - Each cycle, if candidate < NUM_WORDS: write it to slot s and increment s. Otherwise discard it (rejection).
  - After slot 4 is written -> RUN.
  - With NUM_WORDS=256, FILL lasts exactly 5 cycles.
- RUN, letter L accepted:
  - If tot==25: ignore (no error).
  - Otherwise: type[5*tot +: 5] <= L; tot++.
  - If correct==tot, tot<cur_len, and L==cur_word[5*tot +: 5]: correct++.
  - Otherwise: err_cnt++.
- RUN, backspace accepted:
  - If tot==0: no change.
  - Otherwise: clear type char tot-1; tot--.
  - If correct==tot (old value): correct--.
- RUN, space accepted:
  - If correct==cur_len and tot==cur_len: accept the word.
    - Shift the window: slot k <= slot k+1 for k=0..3; slot 4 <= 0.
    - Clear type, tot, correct.
    - words_done++; chars_done += cur_len+1.
    - If words_done+1 == TARGET_WORDS -> DONE; else -> REFILL.
  - Otherwise: err_cnt++ and nothing else changes.
- REFILL: rejection-sample exactly as FILL, writing slot 4 only; -> RUN when written. key_ready is low throughout, so keys are not accepted.
- DONE: all outputs hold; keys are not accepted. start -> FILL with counters, type, and rd cleared as in IDLE.
- start in FILL/REFILL/RUN: ignored.
- cur_len/cur_word are sampled combinationally in the same cycle as the key; they are valid because cur_id is stable in RUN.

Test Plan:
1. NUM_WORDS=256: rst, then start. busy=1 and key_ready=0 for exactly 5 cycles, then RUN. rd slots equal a reference-LFSR model's low bytes for those 5 cycles; rd[59:50]=0 and each field's bits 9:8 = 0.
2. cur_len=3, cur_word chars {3,1,20} ("cat"); keys 3,1,20. Expect type[14:0]={20,1,3}, tot=3, correct=3, err_cnt=0. Then space: slot0 <= old slot1, type=0, tot=0, correct=0, words_done=1, chars_done=4, REFILL then RUN.
3. Same word; keys 3,2,20. Expect correct=1, tot=3, err_cnt=2. Two backspaces: tot=1, correct=1, type[14:5]=0. Then keys 1,20: correct=3, err_cnt=2.
4. Space with tot=2, cur_len=3: window unchanged, err_cnt+1. Backspace at tot=0: no change. 26 letters: tot stays 25 and char 25 is not written. key_valid during REFILL: no change to any counter.
5. NUM_WORDS=1: FILL/REFILL accept only candidates equal to 0 (verify cycle count against the model). TARGET_WORDS=2: the second accepted word gives done=1 and key_ready=0; a following start clears all counters and refills.
6. Assert rst in the middle of REFILL and in the middle of RUN with start/key_valid high. Next cycle: every output 0, state IDLE, LFSR=SEED.
